// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
// Optional signed operands: define BIN2BCD_SIGNED_EN.
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [3:0] digit_t;

   localparam digit_t ADD3_TH  = 4'd5;
   localparam digit_t ADD3_VAL = 4'd3;

   // digits of 2^w-1 = floor(w*log10(2))+1
   function automatic int min_digits(input int w);
      return (w * 30103) / 100000 + 1;
   endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Operand/result handshake bundle for bin2bcd_iter.
// Signed operand mode is selected by BIN2BCD_SIGNED_EN in the top.
interface bin2bcd_if #(
   parameter int W = 8,
   parameter int D = 3
);

   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_bin;
   logic           out_valid;
   logic           out_ready;
   logic [4*D-1:0] out_bcd;
   logic           out_ovf;
   logic           out_neg;

   modport master (
      output in_valid, in_bin, out_ready,
      input  in_ready, out_valid, out_bcd, out_ovf, out_neg
   );

   modport slave (
      input  in_valid, in_bin, out_ready,
      output in_ready, out_valid, out_bcd, out_ovf, out_neg
   );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
// Used by bin2bcd_iter (BIN2BCD_SIGNED_EN has no effect here).
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  digit_t d,
   output digit_t q
);

   assign q = (d >= ADD3_TH) ? d + ADD3_VAL : d;

endmodule

// File: rtl/bin2bcd_iter.sv
// Iterative shift-and-add-3 binary to packed BCD converter, one bit per cycle.
// Define BIN2BCD_SIGNED_EN for two's complement operands with sign output.
module bin2bcd_iter
   import bin2bcd_pkg::*;
#(
   parameter int W = 8,
   parameter int D = 3
) (
   input logic       clk,
   input logic       rst,
   bin2bcd_if.slave  bus
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   state_t         state;
   state_t         state_nx;
   digit_t [D-1:0] dig_q;
   digit_t [D-1:0] adj;
   digit_t [D-1:0] dig_sh;
   logic [W-1:0]   op_q;
   logic [W-1:0]   mag;
   logic [CW-1:0]  cnt_q;
   logic           ovf_q;
   logic           acc;

   assign acc = (state == IDLE) && bus.in_valid;

   genvar i;
   generate
      for (i = 0; i < D; i++) begin : g_dig
         bcd_digit_adj u_adj (
            .d (dig_q[i]),
            .q (adj[i])
         );
         // carry between digits is the MSB of the adjusted lower digit
         if (i == 0) begin : g_lsd
            assign dig_sh[i] = {adj[i][2:0], op_q[W-1]};
         end else begin : g_hsd
            assign dig_sh[i] = {adj[i][2:0], adj[i-1][3]};
         end
      end
   endgenerate

`ifdef BIN2BCD_SIGNED_EN
   logic neg_q;
   logic sgn;

   assign sgn         = bus.in_bin[W-1];
   assign mag         = sgn ? (~bus.in_bin + 1'b1) : bus.in_bin;
   assign bus.out_neg = neg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         neg_q <= 1'b0;
      end else if (acc) begin
         neg_q <= sgn;
      end
   end
`else
   assign mag         = bus.in_bin;
   assign bus.out_neg = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.in_valid)  state_nx = SHIFT;
         SHIFT:   if (cnt_q == '0)   state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dig_q <= '0;
         op_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (acc) begin
         dig_q <= '0;
         op_q  <= mag;
         cnt_q <= CW'(W - 1);
         ovf_q <= 1'b0;
      end else if (state == SHIFT) begin
         dig_q <= dig_sh;
         op_q  <= op_q << 1;
         ovf_q <= ovf_q | adj[D-1][3];
         if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_bcd   = dig_q;
   assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Randomized and directed check of bin2bcd_iter against an arithmetic model.
// Build with or without BIN2BCD_SIGNED_EN; the model follows the same macro.
module tb_bin2bcd_iter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ncmp = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   bin2bcd_if #(.W(8), .D(3)) ifa ();
   bin2bcd_if #(.W(8), .D(2)) ifb ();

   bin2bcd_iter #(.W(8), .D(3)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   bin2bcd_iter #(.W(8), .D(2)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input int s, input logic v, input logic [7:0] b,
                      input logic r);
      if (s == 0) begin
         ifa.in_valid = v; ifa.in_bin = b; ifa.out_ready = r;
      end else begin
         ifb.in_valid = v; ifb.in_bin = b; ifb.out_ready = r;
      end
   endtask

   function automatic logic [31:0] rd_rdy(input int s);
      return (s == 0) ? 32'(ifa.in_ready) : 32'(ifb.in_ready);
   endfunction

   function automatic logic [31:0] rd_ov(input int s);
      return (s == 0) ? 32'(ifa.out_valid) : 32'(ifb.out_valid);
   endfunction

   function automatic logic [31:0] rd_bcd(input int s);
      return (s == 0) ? 32'(ifa.out_bcd) : 32'(ifb.out_bcd);
   endfunction

   function automatic logic [31:0] rd_ovf(input int s);
      return (s == 0) ? 32'(ifa.out_ovf) : 32'(ifb.out_ovf);
   endfunction

   function automatic logic [31:0] rd_neg(input int s);
      return (s == 0) ? 32'(ifa.out_neg) : 32'(ifb.out_neg);
   endfunction

   // decimal digits by repeated division; overflow if anything is left
   task automatic model(input int s, input logic [7:0] v,
                        output logic [31:0] bcd, output logic [31:0] ovf,
                        output logic [31:0] neg);
      int nd;
      int mag;
      nd  = (s == 0) ? 3 : 2;
      mag = int'(v);
      neg = 0;
`ifdef BIN2BCD_SIGNED_EN
      if (v[7]) begin
         mag = 256 - int'(v);
         neg = 1;
      end
`endif
      bcd = 0;
      for (int i = 0; i < nd; i++) begin
         bcd = bcd | (32'(mag % 10) << (4 * i));
         mag = mag / 10;
      end
      ovf = (mag != 0) ? 1 : 0;
   endtask

   // entered and left at #1 after a rising edge with the DUT in IDLE
   task automatic conv(input int s, input logic [7:0] v, input int hold);
      logic [31:0] eb, eo, en;
      int k;
      model(s, v, eb, eo, en);
      chk("idle_ready", rd_rdy(s), 1);
      drv(s, 1'b1, v, 1'b0);
      @(posedge clk); #1;
      chk("busy_ready", rd_rdy(s), 0);
      k = 0;
      while (rd_ov(s) == 0 && k < 40) begin
         drv(s, 1'b1, 8'($urandom), 1'b0);
         @(posedge clk); #1;
         k++;
      end
      chk("latency", 32'(k + 1), 9);
      chk("bcd", rd_bcd(s), eb);
      chk("ovf", rd_ovf(s), eo);
      chk("neg", rd_neg(s), en);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", rd_ov(s), 1);
         chk("hold_bcd", rd_bcd(s), eb);
         chk("hold_ready", rd_rdy(s), 0);
      end
      drv(s, 1'b0, 8'h00, 1'b1);
      @(posedge clk); #1;
      chk("post_ready", rd_rdy(s), 1);
      chk("post_valid", rd_ov(s), 0);
      drv(s, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      logic [7:0] dirv [6];
      drv(0, 1'b0, 8'h00, 1'b0);
      drv(1, 1'b0, 8'h00, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("rst_ready", rd_rdy(s), 1);
         chk("rst_valid", rd_ov(s), 0);
         chk("rst_bcd", rd_bcd(s), 0);
         chk("rst_ovf", rd_ovf(s), 0);
         chk("rst_neg", rd_neg(s), 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      conv(0, 8'd255, 5);
      dirv = '{8'd0, 8'd100, 8'h80, 8'hFF, 8'h7F, 8'd1};
      for (int i = 0; i < 6; i++) conv(0, dirv[i], 0);

      conv(1, 8'd255, 0);
      conv(1, 8'd99, 1);
      conv(1, 8'd0, 0);
      conv(1, 8'd100, 0);

      // reset in the middle of a conversion
      drv(0, 1'b1, 8'd200, 1'b0);
      @(posedge clk); #1;
      drv(0, 1'b0, 8'h00, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_ready", rd_rdy(0), 1);
      chk("mid_rst_valid", rd_ov(0), 0);
      chk("mid_rst_bcd", rd_bcd(0), 0);
      drv(0, 1'b0, 8'h00, 1'b0);
      conv(0, 8'd42, 0);

      for (int i = 0; i < 20; i++) begin
         conv(0, 8'($urandom), int'($urandom_range(0, 2)));
         conv(1, 8'($urandom), int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
